qam16_demodulator: RTL and testbench
====================================

QAM16_DEMODULATOR -- requirements
Module: qam16_demodulator

Interface
REQ-001 SHALL have parameter SPS, default 32, meaning samples per symbol (power of two, at least 8).
REQ-002 SHALL have parameter SHIFT, default 20, meaning the arithmetic right shift applied to the accumulator before slicing.
REQ-003 SHALL have parameter TH, default 2048, meaning the signed 16-bit outer decision threshold.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 start  input  1  receive enable; high means demodulate, low means abort and idle.
REQ-007 mixed_input  input  20  signed received passband sample, one per clk.
REQ-008 sin  input  16  signed local-oscillator sine, phase-coherent with the transmit LO.
REQ-009 cos  input  16  signed local-oscillator cosine, phase-coherent with the transmit LO.
REQ-010 sym_data  output  4  decided symbol; [3:2] is the I pair, [1:0] is the Q pair.
REQ-011 sym_valid  output  1  one-cycle strobe that qualifies sym_data.
REQ-012 serial_out  output  1  serialized symbol bit, MSB first.
REQ-013 bit_flag  output  1  high while serial_out carries a valid bit.

Function
REQ-014 SHALL implement FSM states IDLE and INTEG; IDLE->INTEG when start=1; INTEG->IDLE when start=0.
REQ-015 SHALL, in INTEG, register the products mixed_input*cos (I) and mixed_input*sin (Q) each cycle, signed 36-bit, with no truncation.
REQ-016 SHALL accumulate each product into a signed accumulator of width 36+log2(SPS)+1, with no wrap possible.
REQ-017 SHALL count samples 0..SPS-1 using a sample counter that wraps; on count SPS-1 the accumulator SHALL dump into a hold register and reload with the next product, losing no sample.
REQ-018 SHALL compute the decision D = hold >>> SHIFT, saturated to signed 16-bit [-32768, 32767].
REQ-019 SHALL slice D per axis as follows: D < -TH -> 2'b00; -TH <= D < 0 -> 2'b01; 0 <= D < TH -> 2'b11; D >= TH -> 2'b10.
REQ-020 SHALL assert sym_valid for exactly one cycle, two rising edges after the edge that samples the symbol's last input sample; sym_data SHALL hold until the next strobe.
REQ-021 SHALL, in the cycle after sym_valid, shift sym_data out MSB first over 4 consecutive cycles with bit_flag high, then hold bit_flag and serial_out at 0.
REQ-022 SHALL drop start=0 mid-symbol without producing a strobe: counter, accumulators and products clear and the partial symbol is discarded; a serialization already in progress SHALL complete.
REQ-023 SHALL, when start reasserts, restart sample counting at 0 on the first sample after start rises.
REQ-024 SHALL require no backpressure: because SPS >= 8, a serialization always ends before the next sym_valid.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state to IDLE and clear the counter, products, accumulators and hold register to 0.
REQ-026 SHALL, while rst=0, drive sym_data=4'b0000, sym_valid=0, serial_out=0 and bit_flag=0.
REQ-027 SHALL resume operation on the first rising edge after rst deasserts, with start sampled on that edge.

Structure
REQ-028 SHALL take the following from package qam16_pkg: the Gray level codes (00=-3, 01=-1, 11=+1, 10=+3), the sample width 20, the LO width 16 and the product width 36.
REQ-029 SHALL place the shifter in a single sub-module, parallel_2_serial (load, serial_out, bit_flag), the mirror of serial_2_parallel.

Verification
REQ-030 cos=16384, sin=0, mixed=+1000 held for 32 cycles -> I D=500 and Q D=0 -> sym_data=4'b1111, then serial_out=1,1,1,1.
REQ-031 cos=16384, sin=0, mixed=+8000 -> I D=4000 -> sym_data=4'b1011; mixed=-8000 -> sym_data=4'b0011.
REQ-032 cos=0, sin=16384, mixed=-1000 -> Q D=-500 -> sym_data=4'b1101.
REQ-033 cos=-32768, mixed=-524288 held for 32 cycles -> D saturates to 32767 -> I bits=2'b10, with no accumulator overflow.
REQ-034 start dropped at sample 20 and reasserted 5 cycles later -> no sym_valid for the aborted symbol; the next strobe comes exactly 32 samples plus 2 edges after restart.
REQ-035 rst pulsed low during serialization -> all outputs are 0 immediately (asynchronously), with no residual bit_flag after release.

Source files
------------

// File: rtl/qam16_pkg.sv
// rtl/qam16_pkg.sv - shared widths, Gray level codes, FSM states and the per-axis slicer
//
// Purpose: constants and types common to the QAM16 demodulator and its shifter.
// Ports: none (package).

package qam16_pkg;

  localparam int SAMPLE_W = 20;  // received passband sample width
  localparam int LO_W     = 16;  // local-oscillator sine/cosine width
  localparam int PROD_W   = 36;  // full-precision sample * LO product width
  localparam int DEC_W    = 16;  // saturated decision width
  localparam int SYM_W    = 4;   // bits per QAM16 symbol

  // Gray-coded amplitude levels: adjacent levels differ in one bit.
  localparam logic [1:0] LVL_M3 = 2'b00;
  localparam logic [1:0] LVL_M1 = 2'b01;
  localparam logic [1:0] LVL_P1 = 2'b11;
  localparam logic [1:0] LVL_P3 = 2'b10;

  typedef enum logic {
    IDLE  = 1'b0,
    INTEG = 1'b1
  } state_e;

  // Map one axis decision onto its Gray level; th is the outer threshold.
  function automatic logic [1:0] slice_axis(input logic signed [DEC_W-1:0] d,
                                            input logic signed [DEC_W-1:0] th);
    logic [1:0] lvl;
    if (d < -th) begin
      lvl = LVL_M3;
    end else if (d[DEC_W-1]) begin
      lvl = LVL_M1;
    end else if (d < th) begin
      lvl = LVL_P1;
    end else begin
      lvl = LVL_P3;
    end
    return lvl;
  endfunction

endpackage

// File: rtl/qam16_demodulator_p2s.sv
// rtl/qam16_demodulator_p2s.sv - 4-bit parallel-to-serial shifter for decided symbols
//
// Purpose: loads a symbol and emits it MSB first over four cycles with bit_flag high.
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   load       in   one-cycle load strobe
//   data       in   [3:0] symbol to serialize
//   serial_out out  current serial bit (0 when idle)
//   bit_flag   out  high while serial_out carries a valid bit

module parallel_2_serial
  import qam16_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SYM_W-1:0] data,
  output logic             serial_out,
  output logic             bit_flag
);

  logic [SYM_W-2:0] shreg_q, shreg_d;  // bits still to be sent, next one at the top
  logic [1:0]       left_q, left_d;    // number of bits still held in shreg_q
  logic             out_q, out_d;
  logic             flag_q, flag_d;

  always_comb begin
    shreg_d = shreg_q;
    left_d  = left_q;
    out_d   = 1'b0;
    flag_d  = 1'b0;
    if (load) begin
      out_d   = data[SYM_W-1];
      flag_d  = 1'b1;
      shreg_d = data[SYM_W-2:0];
      left_d  = 2'd3;
    end else if (left_q != 2'd0) begin
      out_d   = shreg_q[SYM_W-2];
      flag_d  = 1'b1;
      shreg_d = {shreg_q[SYM_W-3:0], 1'b0};
      left_d  = left_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q <= '0;
      left_q  <= '0;
      out_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      left_q  <= left_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign serial_out = out_q;
  assign bit_flag   = flag_q;

endmodule

// File: rtl/qam16_demodulator.sv
// rtl/qam16_demodulator.sv - coherent QAM16 integrate-and-dump demodulator with serial output
//
// Purpose: mixes each sample with the LO, integrates SPS products per axis, slices the
// scaled sums into Gray levels and serializes the resulting 4-bit symbol.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   start       in   high = demodulate, low = abort and idle
//   mixed_input in   [19:0] signed passband sample, one per clk
//   sin, cos    in   [15:0] signed coherent LO
//   sym_data    out  [3:0] decided symbol, {I pair, Q pair}, held between strobes
//   sym_valid   out  one-cycle strobe qualifying sym_data
//   serial_out  out  serialized symbol bit, MSB first
//   bit_flag    out  high while serial_out is valid

module qam16_demodulator
  import qam16_pkg::*;
#(
  parameter int                SPS   = 32,
  parameter int                SHIFT = 20,
  parameter logic signed [15:0] TH   = 16'sd2048
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic signed [SAMPLE_W-1:0] mixed_input,
  input  logic signed [LO_W-1:0]     sin,
  input  logic signed [LO_W-1:0]     cos,
  output logic        [SYM_W-1:0]    sym_data,
  output logic                       sym_valid,
  output logic                       serial_out,
  output logic                       bit_flag
);

  localparam int CNT_W = $clog2(SPS);
  localparam int ACC_W = PROD_W + CNT_W + 1;  // SPS full-scale products cannot wrap

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(32768));

  state_e                    state_q, state_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;
  logic signed [PROD_W-1:0]  prod_i_q, prod_i_d, prod_q_q, prod_q_d;
  logic                      last_q, last_d;     // product register holds a symbol's final sample
  logic signed [ACC_W-1:0]   acc_i_q, acc_i_d, acc_q_q, acc_q_d;
  logic signed [ACC_W-1:0]   hold_i_q, hold_i_d, hold_q_q, hold_q_d;
  logic                      dump_q, dump_d;     // hold registers were just loaded
  logic        [SYM_W-1:0]   sym_data_q, sym_data_d;
  logic                      sym_valid_q;

  logic                      run;
  logic signed [PROD_W-1:0]  mix_x, cos_x, sin_x;
  logic signed [ACC_W-1:0]   sum_i, sum_q;
  logic signed [ACC_W-1:0]   shr_i, shr_q;
  logic signed [DEC_W-1:0]   dec_i, dec_q;

  function automatic logic signed [DEC_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DEC_W-1:0] r;
    if (v > SAT_MAX) begin
      r = 16'sh7fff;
    end else if (v < SAT_MIN) begin
      r = 16'sh8000;
    end else begin
      r = v[DEC_W-1:0];
    end
    return r;
  endfunction

  // Operands are sign-extended to the product width so the multiply is exact.
  assign mix_x = {{(PROD_W-SAMPLE_W){mixed_input[SAMPLE_W-1]}}, mixed_input};
  assign cos_x = {{(PROD_W-LO_W){cos[LO_W-1]}}, cos};
  assign sin_x = {{(PROD_W-LO_W){sin[LO_W-1]}}, sin};

  assign sum_i = acc_i_q + {{(ACC_W-PROD_W){prod_i_q[PROD_W-1]}}, prod_i_q};
  assign sum_q = acc_q_q + {{(ACC_W-PROD_W){prod_q_q[PROD_W-1]}}, prod_q_q};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)  state_d = INTEG;
      INTEG:   if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A sample is taken on every edge that sees start high, so the first edge after
  // start rises captures sample 0. Leaving INTEG clears the partial symbol.
  assign run = (state_d == INTEG);

  always_comb begin
    cnt_d    = '0;
    prod_i_d = '0;
    prod_q_d = '0;
    last_d   = 1'b0;
    acc_i_d  = '0;
    acc_q_d  = '0;
    if (run) begin
      cnt_d    = cnt_q + CNT_W'(1);
      prod_i_d = mix_x * cos_x;
      prod_q_d = mix_x * sin_x;
      last_d   = (cnt_q == CNT_W'(SPS - 1));
      // On the dump edge the accumulator restarts empty; the next symbol's first
      // product is already registered and is added on the following edge.
      acc_i_d  = last_q ? '0 : sum_i;
      acc_q_d  = last_q ? '0 : sum_q;
    end
  end

  // A complete symbol is dumped even if start falls on the same edge: all of its
  // samples were already captured, so it is not a mid-symbol abort.
  always_comb begin
    hold_i_d = hold_i_q;
    hold_q_d = hold_q_q;
    dump_d   = 1'b0;
    if (last_q) begin
      hold_i_d = sum_i;
      hold_q_d = sum_q;
      dump_d   = 1'b1;
    end
  end

  assign shr_i = hold_i_q >>> SHIFT;
  assign shr_q = hold_q_q >>> SHIFT;
  assign dec_i = sat16(shr_i);
  assign dec_q = sat16(shr_q);

  always_comb begin
    sym_data_d = sym_data_q;
    if (dump_q) begin
      sym_data_d = {slice_axis(dec_i, TH), slice_axis(dec_q, TH)};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      prod_i_q    <= '0;
      prod_q_q    <= '0;
      last_q      <= 1'b0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      hold_i_q    <= '0;
      hold_q_q    <= '0;
      dump_q      <= 1'b0;
      sym_data_q  <= '0;
      sym_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prod_i_q    <= prod_i_d;
      prod_q_q    <= prod_q_d;
      last_q      <= last_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      hold_i_q    <= hold_i_d;
      hold_q_q    <= hold_q_d;
      dump_q      <= dump_d;
      sym_data_q  <= sym_data_d;
      sym_valid_q <= dump_q;
    end
  end

  assign sym_data  = sym_data_q;
  assign sym_valid = sym_valid_q;

  parallel_2_serial u_p2s (
    .clk        (clk),
    .rst        (rst),
    .load       (sym_valid_q),
    .data       (sym_data_q),
    .serial_out (serial_out),
    .bit_flag   (bit_flag)
  );

endmodule

// File: tb/tb_qam16_demodulator.sv
// tb/tb_qam16_demodulator.sv - directed self-checking bench for qam16_demodulator

module tb_qam16_demodulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [19:0] mixed_input;
  logic signed [15:0] sin;
  logic signed [15:0] cos;
  logic [3:0]         sym_data;
  logic               sym_valid;
  logic               serial_out;
  logic               bit_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  qam16_demodulator dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mixed_input (mixed_input),
    .sin         (sin),
    .cos         (cos),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .serial_out  (serial_out),
    .bit_flag    (bit_flag)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Returns the number of negedges until sym_valid is seen, or -1 on timeout.
  task automatic wait_strobe(output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!sym_valid && waited < 8);
    if (!sym_valid) waited = -1;
  endtask

  task automatic verify_serial(input logic [3:0] expected, input string tag);
    logic [3:0] e;
    e = expected;
    for (int b = 3; b >= 0; b--) begin
      step();
      check({tag, " bit_flag"}, bit_flag, 1);
      check({tag, " serial bit"}, serial_out, e[b]);
      if (b == 3) check({tag, " one-cycle strobe"}, sym_valid, 0);
    end
    step();
    check({tag, " bit_flag idle"}, bit_flag, 0);
    check({tag, " serial idle"}, serial_out, 0);
    check({tag, " data held"}, sym_data, expected);
  endtask

  task automatic run_symbol(input logic signed [19:0] mix, input logic signed [15:0] c,
                            input logic signed [15:0] s, input logic [3:0] expected,
                            input string tag);
    int strobes;
    int waited;
    strobes     = 0;
    mixed_input = mix;
    cos         = c;
    sin         = s;
    start       = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (sym_valid) strobes++;
    end
    check({tag, " no early strobe"}, strobes, 0);
    start = 1'b0;
    wait_strobe(waited);
    check({tag, " latency"}, waited, 2);
    check({tag, " sym_data"}, sym_data, expected);
    verify_serial(expected, tag);
  endtask

  initial begin
    int waited;
    int strobes;
    int bad;

    rst         = 1'b0;
    start       = 1'b0;
    mixed_input = '0;
    sin         = '0;
    cos         = '0;
    step();
    check("reset sym_data", sym_data, 0);
    check("reset sym_valid", sym_valid, 0);
    check("reset serial_out", serial_out, 0);
    check("reset bit_flag", bit_flag, 0);
    rst = 1'b1;

    // Basic constellation points: I D=500, Q D=0.
    run_symbol(20'sd1000, 16'sd16384, 16'sd0, 4'b1111, "pos1000");
    run_symbol(-20'sd1000, 16'sd0, 16'sd16384, 4'b1101, "q_neg1000");

    // Threshold boundaries: D=2048, D=-2048, D=2047, D=-1, Q axis D=2048.
    run_symbol(20'sd4096, 16'sd16384, 16'sd0, 4'b1011, "i_eq_th");
    run_symbol(-20'sd4096, 16'sd16384, 16'sd0, 4'b0111, "i_eq_neg_th");
    run_symbol(20'sd4095, 16'sd16384, 16'sd0, 4'b1111, "i_below_th");
    run_symbol(-20'sd1, 16'sd16384, 16'sd0, 4'b0111, "i_minus_one");
    run_symbol(20'sd4096, 16'sd0, 16'sd16384, 4'b1110, "q_eq_th");

    // Saturation at both ends of the decision range.
    run_symbol(-20'sd524288, -16'sd32768, 16'sd0, 4'b1011, "sat_pos");
    run_symbol(-20'sd524288, 16'sd32767, 16'sd0, 4'b0011, "sat_neg");

    // Two back-to-back symbols with start held high: +8000 then -8000.
    mixed_input = 20'sd8000;
    cos         = 16'sd16384;
    sin         = 16'sd0;
    start       = 1'b1;
    for (int i = 0; i < 32; i++) step();
    mixed_input = -20'sd8000;
    wait_strobe(waited);
    check("b2b first latency", waited, 2);
    check("b2b first sym_data", sym_data, 4'b1011);
    verify_serial(4'b1011, "b2b first");
    for (int i = 0; i < 25; i++) step();
    start = 1'b0;
    wait_strobe(waited);
    check("b2b second latency", waited, 2);
    check("b2b second sym_data", sym_data, 4'b0011);
    verify_serial(4'b0011, "b2b second");

    // Abort at sample 20, idle 5 cycles, then a fresh symbol from sample 0.
    mixed_input = 20'sd8000;
    cos         = 16'sd16384;
    sin         = 16'sd0;
    start       = 1'b1;
    strobes     = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sym_valid) strobes++;
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (sym_valid) strobes++;
    end
    check("abort no strobe", strobes, 0);
    run_symbol(-20'sd1000, 16'sd16384, 16'sd0, 4'b0111, "after abort");

    // Asynchronous reset in the middle of serialization.
    mixed_input = 20'sd1000;
    cos         = 16'sd16384;
    sin         = 16'sd0;
    start       = 1'b1;
    for (int i = 0; i < 32; i++) step();
    start = 1'b0;
    wait_strobe(waited);
    check("rst test latency", waited, 2);
    step();
    check("rst test serializing", bit_flag, 1);
    #2 rst = 1'b0;
    #1;
    check("async rst sym_data", sym_data, 0);
    check("async rst sym_valid", sym_valid, 0);
    check("async rst serial_out", serial_out, 0);
    check("async rst bit_flag", bit_flag, 0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bit_flag || serial_out || sym_valid) bad++;
    end
    check("no residual after rst", bad, 0);
    run_symbol(20'sd1000, 16'sd16384, 16'sd0, 4'b1111, "after rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
